// File: rtl/pixel_frame_writer.sv
// -----------------------------------------------------------------------------
// pixel_frame_writer
//
// Last stage of the render pipeline. It takes one formatted pixel per valid
// beat and writes it into a double-buffered 12-bit frame buffer through a
// registered ready/valid memory write port. A small FIFO absorbs memory stalls
// because the upstream pipeline cannot be stalled. A two-state machine holds
// the write path after the last pixel of a frame. At the next vsync it then
// hands the finished back buffer to the display.
//
// Handshake: a write transfers on every rising clk_in edge where
// wr_valid_out && wr_ready_in. While wr_valid_out is high and wr_ready_in is
// low, wr_addr_out and wr_data_out hold steady. wr_valid_out never drops
// without a transfer.
//
// Ports
//   clk_in, rst_n_in         clock, asynchronous active-low reset
//   x_in, y_in               pixel coordinates
//   block_visible_in         1: use {r,g,b}, 0: use BG_COLOR
//   r_in, g_in, b_in         4-bit colour channels
//   valid_in                 pixel beat (no back-pressure)
//   vsync_in                 single-cycle display vsync
//   wr_valid_out/ready_in    memory write handshake
//   wr_addr_out              {back buffer index, y*WIDTH+x}
//   wr_data_out              {r,g,b}
//   front_sel_out            buffer currently displayed
//   frame_done_out           one-cycle pulse when buffers swap
//   overflow_out             sticky, set when any pixel was dropped
//   drop_count_out           saturating count of dropped pixels
//   state_dbg_out            frame-swap FSM state (0 FILL, 1 WAIT_SWAP)
// -----------------------------------------------------------------------------
module pixel_frame_writer #(
    parameter int          WIDTH      = 1024,
    parameter int          HEIGHT     = 768,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [11:0] BG_COLOR   = 12'h000,
    parameter int          ADDR_W     = 20
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic [10:0]       x_in,
    input  logic [9:0]        y_in,
    input  logic              block_visible_in,
    input  logic [3:0]        r_in,
    input  logic [3:0]        g_in,
    input  logic [3:0]        b_in,
    input  logic              valid_in,
    input  logic              vsync_in,
    output logic              wr_valid_out,
    input  logic              wr_ready_in,
    output logic [ADDR_W:0]   wr_addr_out,
    output logic [11:0]       wr_data_out,
    output logic              front_sel_out,
    output logic              frame_done_out,
    output logic              overflow_out,
    output logic [15:0]       drop_count_out,
    output logic              state_dbg_out
);

    localparam int IDX_W   = $clog2(FIFO_DEPTH);
    localparam int PTR_W   = IDX_W + 1;
    localparam int ENTRY_W = 1 + ADDR_W + 12;

    localparam logic [10:0] X_LIM  = 11'(WIDTH);
    localparam logic [9:0]  Y_LIM  = 10'(HEIGHT);
    localparam logic [10:0] X_LAST = 11'(WIDTH - 1);
    localparam logic [9:0]  Y_LAST = 10'(HEIGHT - 1);

    typedef enum logic {
        FILL      = 1'b0,
        WAIT_SWAP = 1'b1
    } state_e;

    // ------------------------------------------------------------------
    // Input filter and FIFO entry formation
    // ------------------------------------------------------------------
    logic               in_ok;
    logic               in_last;
    logic [ADDR_W-1:0]  in_addr;
    logic [11:0]        in_color;
    logic [ENTRY_W-1:0] push_entry;

    assign in_ok      = valid_in && (x_in < X_LIM) && (y_in < Y_LIM);
    assign in_last    = (x_in == X_LAST) && (y_in == Y_LAST);
    assign in_addr    = ADDR_W'(y_in) * ADDR_W'(WIDTH) + ADDR_W'(x_in);
    assign in_color   = block_visible_in ? {r_in, g_in, b_in} : BG_COLOR;
    assign push_entry = {in_last, in_addr, in_color};

    // ------------------------------------------------------------------
    // FIFO storage and pointers (extra MSB separates full from empty)
    // ------------------------------------------------------------------
    logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   fifo_count;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] rd_entry;

    assign fifo_count = wr_ptr_q - rd_ptr_q;
    assign fifo_full  = (fifo_count == PTR_W'(FIFO_DEPTH));
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign rd_entry   = mem_q[rd_ptr_q[IDX_W-1:0]];

    // ------------------------------------------------------------------
    // Output register, FSM and status state
    // ------------------------------------------------------------------
    state_e             state_q, state_d;
    logic               out_valid_q, out_valid_d;
    logic [ADDR_W:0]    out_addr_q, out_addr_d;
    logic [11:0]        out_data_q, out_data_d;
    logic               out_last_q, out_last_d;
    logic               front_sel_q, front_sel_d;
    logic               frame_done_q, frame_done_d;
    logic               overflow_q, overflow_d;
    logic [15:0]        drop_cnt_q, drop_cnt_d;

    logic xfer;
    logic pop_allow;
    logic swap;
    logic pop;
    logic push;
    logic drop;

    assign xfer = out_valid_q && wr_ready_in;

    // Pops stop once the last pixel of a frame is transferring, so nothing
    // from the next frame is loaded before the swap decides its buffer.
    assign pop  = pop_allow && !fifo_empty &&
                  (!out_valid_q || (xfer && !out_last_q));
    assign push = in_ok && (!fifo_full || pop);
    assign drop = in_ok && !push;

    // FSM: state register
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:      if (xfer && out_last_q) state_d = WAIT_SWAP;
            WAIT_SWAP: if (vsync_in)           state_d = FILL;
            default:                           state_d = FILL;
        endcase
    end

    // FSM: outputs
    always_comb begin
        pop_allow = 1'b0;
        swap      = 1'b0;
        case (state_q)
            FILL:      pop_allow = 1'b1;
            WAIT_SWAP: swap      = vsync_in;
            default:   pop_allow = 1'b0;
        endcase
    end

    // Next-state for datapath and status registers
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        out_valid_d  = out_valid_q;
        out_addr_d   = out_addr_q;
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;
        front_sel_d  = front_sel_q ^ swap;
        frame_done_d = swap;
        overflow_d   = overflow_q | drop;
        drop_cnt_d   = drop_cnt_q;

        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);

        if (pop) begin
            rd_ptr_d    = rd_ptr_q + PTR_W'(1);
            out_valid_d = 1'b1;
            // The write targets the buffer not on screen at load time.
            out_addr_d  = {~front_sel_q, rd_entry[12 +: ADDR_W]};
            out_data_d  = rd_entry[11:0];
            out_last_d  = rd_entry[ENTRY_W-1];
        end else if (xfer) begin
            out_valid_d = 1'b0;
        end

        if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            out_valid_q  <= 1'b0;
            out_addr_q   <= '0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            front_sel_q  <= 1'b0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            out_valid_q  <= out_valid_d;
            out_addr_q   <= out_addr_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            front_sel_q  <= front_sel_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk_in) begin
        if (push) mem_q[wr_ptr_q[IDX_W-1:0]] <= push_entry;
    end

    assign wr_valid_out   = out_valid_q;
    assign wr_addr_out    = out_addr_q;
    assign wr_data_out    = out_data_q;
    assign front_sel_out  = front_sel_q;
    assign frame_done_out = frame_done_q;
    assign overflow_out   = overflow_q;
    assign drop_count_out = drop_cnt_q;
    assign state_dbg_out  = state_q;

endmodule

// File: tb/tb_pixel_frame_writer.sv
module tb_pixel_frame_writer;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic [10:0] x_in;
  logic [9:0]  y_in;
  logic        block_visible_in;
  logic [3:0]  r_in, g_in, b_in;
  logic        valid_in;
  logic        vsync_in;
  logic        wr_valid_out;
  logic        wr_ready_in;
  logic [20:0] wr_addr_out;
  logic [11:0] wr_data_out;
  logic        front_sel_out;
  logic        frame_done_out;
  logic        overflow_out;
  logic [15:0] drop_count_out;
  logic        state_dbg_out;

  int checks = 0;
  int errors = 0;

  // expected writes: {addr[20:0], data[11:0]}
  logic [32:0] exp_q[$];

  pixel_frame_writer dut (
    .clk_in           (clk_in),
    .rst_n_in         (rst_n_in),
    .x_in             (x_in),
    .y_in             (y_in),
    .block_visible_in (block_visible_in),
    .r_in             (r_in),
    .g_in             (g_in),
    .b_in             (b_in),
    .valid_in         (valid_in),
    .vsync_in         (vsync_in),
    .wr_valid_out     (wr_valid_out),
    .wr_ready_in      (wr_ready_in),
    .wr_addr_out      (wr_addr_out),
    .wr_data_out      (wr_data_out),
    .front_sel_out    (front_sel_out),
    .frame_done_out   (frame_done_out),
    .overflow_out     (overflow_out),
    .drop_count_out   (drop_count_out),
    .state_dbg_out    (state_dbg_out)
  );

  // clock / reset
  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver: one pixel beat, exactly one cycle
  task automatic beat(input int x, input int y, input logic vis,
                      input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
    x_in = 11'(x);
    y_in = 10'(y);
    block_visible_in = vis;
    r_in = r;
    g_in = g;
    b_in = b;
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
  endtask

  function automatic logic [32:0] exp_word(input logic msb, input int x, input int y,
                                           input logic [11:0] d);
    logic [20:0] a;
    a = {msb, 20'(y * 1024 + x)};
    return {a, d};
  endfunction

  // scoreboard: compare the current write port against the queue head
  task automatic check_head(input string tag);
    logic [32:0] w;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed write with empty expected queue", tag);
    end else begin
      w = exp_q.pop_front();
      check({tag, " valid"}, 32'(wr_valid_out), 32'd1);
      check({tag, " addr"}, 32'(wr_addr_out), 32'(w[32:12]));
      check({tag, " data"}, 32'(wr_data_out), 32'(w[11:0]));
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " wr_valid"}, 32'(wr_valid_out), 32'd0);
    check({tag, " wr_addr"}, 32'(wr_addr_out), 32'd0);
    check({tag, " wr_data"}, 32'(wr_data_out), 32'd0);
    check({tag, " front_sel"}, 32'(front_sel_out), 32'd0);
    check({tag, " frame_done"}, 32'(frame_done_out), 32'd0);
    check({tag, " overflow"}, 32'(overflow_out), 32'd0);
    check({tag, " drop_count"}, 32'(drop_count_out), 32'd0);
    check({tag, " state"}, 32'(state_dbg_out), 32'd0);
  endtask

  initial begin
    logic [3:0] c;

    rst_n_in = 1'b0;
    x_in = '0;
    y_in = '0;
    block_visible_in = 1'b0;
    r_in = '0;
    g_in = '0;
    b_in = '0;
    valid_in = 1'b0;
    vsync_in = 1'b0;
    wr_ready_in = 1'b1;

    // reset state
    #2;
    check_reset_values("reset");
    tick();
    tick();
    rst_n_in = 1'b1;
    tick();

    // single visible beat: latency 2, one cycle of valid
    beat(5, 2, 1'b1, 4'hA, 4'h4, 4'hB);
    check("lat1 valid early", 32'(wr_valid_out), 32'd0);
    tick();
    check("lat1 valid", 32'(wr_valid_out), 32'd1);
    check("lat1 addr", 32'(wr_addr_out), 32'h10_0805);
    check("lat1 data", 32'(wr_data_out), 32'hA4B);
    tick();
    check("lat1 one cycle", 32'(wr_valid_out), 32'd0);

    // invisible pixel writes BG_COLOR
    beat(0, 0, 1'b0, 4'hF, 4'hF, 4'hF);
    tick();
    check("bg valid", 32'(wr_valid_out), 32'd1);
    check("bg addr", 32'(wr_addr_out), 32'h10_0000);
    check("bg data", 32'(wr_data_out), 32'h000);
    tick();

    // out-of-range beats are discarded silently
    beat(1024, 0, 1'b1, 4'h1, 4'h2, 4'h3);
    beat(0, 768, 1'b1, 4'h1, 4'h2, 4'h3);
    tick();
    check("oob no write", 32'(wr_valid_out), 32'd0);
    tick();
    check("oob no write2", 32'(wr_valid_out), 32'd0);
    check("oob drop_count", 32'(drop_count_out), 32'd0);
    check("oob overflow", 32'(overflow_out), 32'd0);

    // 10 beats while memory stalls: stable outputs, no drops, ordered drain
    wr_ready_in = 1'b0;
    for (int i = 0; i < 10; i++) begin
      c = 4'(i);
      beat(10 + i, 3, 1'b1, c, ~c, 4'h1);
      exp_q.push_back(exp_word(1'b1, 10 + i, 3, {c, ~c, 4'h1}));
    end
    for (int k = 0; k < 3; k++) begin
      check("stall valid", 32'(wr_valid_out), 32'd1);
      check("stall addr", 32'(wr_addr_out), 32'(exp_q[0][32:12]));
      check("stall data", 32'(wr_data_out), 32'(exp_q[0][11:0]));
      tick();
    end
    check("stall drop_count", 32'(drop_count_out), 32'd0);
    check("stall overflow", 32'(overflow_out), 32'd0);
    wr_ready_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check_head("drain10");
      tick();
    end
    check("drain10 idle", 32'(wr_valid_out), 32'd0);

    // 20 beats while stalled: 17 survive, 3 dropped
    wr_ready_in = 1'b0;
    for (int i = 0; i < 20; i++) begin
      c = 4'(i);
      beat(100 + i, 5, 1'b1, c, 4'h5, 4'hC);
      if (i < 17) exp_q.push_back(exp_word(1'b1, 100 + i, 5, {c, 4'h5, 4'hC}));
    end
    check("ovf overflow", 32'(overflow_out), 32'd1);
    check("ovf drop_count", 32'(drop_count_out), 32'd3);
    wr_ready_in = 1'b1;
    for (int i = 0; i < 17; i++) begin
      check_head("drain17");
      tick();
    end
    check("drain17 idle", 32'(wr_valid_out), 32'd0);
    check("drain17 queue empty", 32'(exp_q.size()), 32'd0);
    check("ovf sticky", 32'(overflow_out), 32'd1);

    // vsync while filling is ignored
    vsync_in = 1'b1;
    tick();
    vsync_in = 1'b0;
    check("fill vsync front", 32'(front_sel_out), 32'd0);
    check("fill vsync done", 32'(frame_done_out), 32'd0);
    check("fill vsync state", 32'(state_dbg_out), 32'd0);

    // last pixel of frame, with vsync coinciding with its transfer
    beat(1023, 767, 1'b1, 4'h1, 4'h2, 4'h3);
    tick();
    check("last valid", 32'(wr_valid_out), 32'd1);
    check("last addr", 32'(wr_addr_out), 32'h1B_FFFF);
    check("last data", 32'(wr_data_out), 32'h123);
    vsync_in = 1'b1;
    tick();
    vsync_in = 1'b0;
    check("coinc state", 32'(state_dbg_out), 32'd1);
    check("coinc front", 32'(front_sel_out), 32'd0);
    check("coinc done", 32'(frame_done_out), 32'd0);
    check("coinc valid", 32'(wr_valid_out), 32'd0);

    // input keeps pushing during WAIT_SWAP but nothing is written
    beat(7, 1, 1'b1, 4'hD, 4'hE, 4'hF);
    for (int k = 0; k < 3; k++) begin
      check("wait no write", 32'(wr_valid_out), 32'd0);
      check("wait state", 32'(state_dbg_out), 32'd1);
      tick();
    end
    check("wait front", 32'(front_sel_out), 32'd0);

    // next vsync swaps; held pixel goes to the new back buffer (MSB 0)
    vsync_in = 1'b1;
    tick();
    vsync_in = 1'b0;
    check("swap front", 32'(front_sel_out), 32'd1);
    check("swap done", 32'(frame_done_out), 32'd1);
    check("swap state", 32'(state_dbg_out), 32'd0);
    check("swap valid", 32'(wr_valid_out), 32'd0);
    tick();
    check("swap done pulse", 32'(frame_done_out), 32'd0);
    check("newframe valid", 32'(wr_valid_out), 32'd1);
    check("newframe addr", 32'(wr_addr_out), 32'h00_0407);
    check("newframe data", 32'(wr_data_out), 32'hDEF);
    tick();
    check("newframe idle", 32'(wr_valid_out), 32'd0);

    // reset mid-burst with the FIFO about half full
    wr_ready_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      beat(200 + i, 9, 1'b1, 4'h7, 4'h7, 4'(i));
    end
    check("pre-reset valid", 32'(wr_valid_out), 32'd1);
    rst_n_in = 1'b0;
    #2;
    check_reset_values("midreset");
    tick();
    rst_n_in = 1'b1;
    wr_ready_in = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("post-reset no stale", 32'(wr_valid_out), 32'd0);
    end
    beat(5, 2, 1'b1, 4'hA, 4'h4, 4'hB);
    tick();
    check("post-reset valid", 32'(wr_valid_out), 32'd1);
    check("post-reset addr", 32'(wr_addr_out), 32'h10_0805);
    check("post-reset data", 32'(wr_data_out), 32'hA4B);
    tick();
    check("post-reset idle", 32'(wr_valid_out), 32'd0);

    // report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
